smpl_capture_ctrl: RTL

//  Downstream of the channel sampler. Takes its 8-bit smpl word (4 time-ordered CH_H/CH_L pairs) on each
//  wrt_smpl strobe and writes it into a circular sample RAM.

---
 rtl/smpl_capture_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/smpl_capture_ctrl.sv
// Circular sample-RAM write controller: pre-trigger fill, arm, trigger, post-trigger count, done.
// Latency: RAM write port (we/waddr/wdata) is registered 1 cycle after the accepting wrt_smpl.
// Backpressure: none; every wrt_smpl in CAPTURE/POST is stored, and the sampler is never stalled.
module smpl_capture_ctrl #(
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    smpl,
    input  logic          wrt_smpl,
    input  logic          run,
    input  logic          stop,
    input  logic          triggered,
    input  logic [AW-1:0] trig_pos,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          armed,
    output logic          capturing,
    output logic          capture_done,
    output logic [AW-1:0] start_addr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_n;
    logic [AW:0]   ptr, ptr_n;
    logic [AW:0]   pre_cnt, pre_n;
    logic [AW:0]   post_cnt, post_n;
    logic [AW-1:0] tpos, tpos_n;
    logic          wr;
    logic          armed_n;
    logic [AW:0]   pre_target;
    logic [AW:0]   pre_target_n;

    // Pre-trigger history needed before a trigger may be accepted.
    assign pre_target   = DEPTH_W - {1'b0, tpos};
    assign pre_target_n = DEPTH_W - {1'b0, tpos_n};

    // Next-state, pointer/counter updates and write-accept decision.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        pre_n   = pre_cnt;
        post_n  = post_cnt;
        tpos_n  = tpos;
        wr      = 1'b0;
        if (stop) begin
            // Abort wins over run/trigger and suppresses any same-cycle write.
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (run) begin
                        ptr_n   = '0;
                        pre_n   = '0;
                        post_n  = '0;
                        tpos_n  = trig_pos;
                        state_n = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (armed && triggered) begin
                        if (tpos == '0) begin
                            // No post-trigger samples wanted: finish without storing this one.
                            state_n = DONE;
                        end else begin
                            state_n = POST;
                            if (wrt_smpl) begin
                                // Same-cycle sample is post-trigger sample number 1.
                                wr     = 1'b1;
                                ptr_n  = ptr + 1'b1;
                                post_n = {{AW{1'b0}}, 1'b1};
                                if (post_n == {1'b0, tpos})
                                    state_n = DONE;
                            end else begin
                                post_n = '0;
                            end
                        end
                    end else if (wrt_smpl) begin
                        wr    = 1'b1;
                        ptr_n = ptr + 1'b1;
                        if (pre_cnt != pre_target)
                            pre_n = pre_cnt + 1'b1;
                    end
                end
                POST: begin
                    if (wrt_smpl) begin
                        wr     = 1'b1;
                        ptr_n  = ptr + 1'b1;
                        post_n = post_cnt + 1'b1;
                        if (post_n == {1'b0, tpos})
                            state_n = DONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        armed_n = (state_n == CAPTURE) && (pre_n == pre_target_n);
    end

    // State, pointers, counters, write port and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            tpos         <= '0;
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            armed        <= 1'b0;
            capturing    <= 1'b0;
            capture_done <= 1'b0;
            start_addr   <= '0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            pre_cnt      <= pre_n;
            post_cnt     <= post_n;
            tpos         <= tpos_n;
            we           <= wr;
            if (wr) begin
                waddr <= ptr[AW-1:0];
                wdata <= smpl;
            end
            armed        <= armed_n;
            capturing    <= (state_n == CAPTURE) || (state_n == POST);
            capture_done <= (state_n == DONE);
            // After the final write the pointer sits on the oldest stored sample.
            if (state_n == DONE && state != DONE)
                start_addr <= ptr_n[AW-1:0];
        end
    end

endmodule
